// File: rtl/jk_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jk_driver
// Brief    : Queues target words and drives J/K excitation to a JK flop bank,
//            then verifies the bank's returned Q against the target.
// Revision : 1.0
// ============================================================================
module jk_driver #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_obs,
    input  logic             clr_err,
    output logic             done,
    output logic             mismatch,
    output logic             busy
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [WIDTH-1:0]   r_cur;
    logic [WIDTH-1:0]   r_tgt;
    logic [WIDTH-1:0]   r_j;
    logic [WIDTH-1:0]   r_k;
    logic               r_done;
    logic               r_mismatch;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_match;
    logic [WIDTH-1:0]   w_head;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_j_nxt;
    logic [WIDTH-1:0]   w_k_nxt;

    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] t,
                                                  input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] v_set;
        logic [WIDTH-1:0] v_clr;
        v_set = t & ~base;
        v_clr = base & ~t;
        if (TOGGLE != 0)
            excite = {v_set | v_clr, v_set | v_clr};
        else
            excite = {v_set, v_clr};
    endfunction

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = tgt_valid & ~w_full;
    assign w_match = (q_obs == r_tgt);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = ~w_empty & ((r_state == ST_IDLE) ||
                                 ((r_state == ST_CHECK) && w_match));

    // Back-to-back targets start from the just-verified target, not r_cur,
    // since r_cur is only being updated at the same edge.
    assign w_base  = (r_state == ST_CHECK) ? r_tgt : r_cur;
    assign {w_j_nxt, w_k_nxt} = excite(w_head, w_base);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= tgt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_tgt      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_j     <= w_j_nxt;
                        r_k     <= w_k_nxt;
                        r_tgt   <= w_head;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_done <= 1'b1;
                        r_cur  <= r_tgt;
                        if (!w_empty) begin
                            r_j     <= w_j_nxt;
                            r_k     <= w_k_nxt;
                            r_tgt   <= w_head;
                            r_state <= ST_DRIVE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_mismatch <= 1'b1;
                        r_state    <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (clr_err) begin
                        r_cur      <= q_obs;
                        r_mismatch <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tgt_ready = ~w_full;
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign busy      = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_jk_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jk_driver
// Brief    : Directed, table-driven bench for jk_driver with JK bank models.
// Revision : 1.0
// ============================================================================
module tb_jk_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       valid0 = 1'b0;
    logic       valid1 = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       clr_err = 1'b0;
    logic       clr1 = 1'b0;
    logic [7:0] stuck = 8'h00;

    logic       ready0, ready1, done0, done1, mis0, mis1, busy0, busy1;
    logic [7:0] j0, k0, j1, k1, q0, q1;

    logic       oready, odone, omis, obusy;
    logic [7:0] oj, ok;

    int total = 0;
    int bad   = 0;

    logic [7:0] sj [4];
    logic [7:0] sk [4];

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] ej;
        logic [7:0] ek;
        logic       s;
    } vec_t;

    jk_driver #(.WIDTH(8), .DEPTH(4), .TOGGLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(valid0), .tgt_data(tdata),
        .tgt_ready(ready0), .j(j0), .k(k0), .q_obs(q0), .clr_err(clr_err),
        .done(done0), .mismatch(mis0), .busy(busy0)
    );

    jk_driver #(.WIDTH(8), .DEPTH(4), .TOGGLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(valid1), .tgt_data(tdata),
        .tgt_ready(ready1), .j(j1), .k(k1), .q_obs(q1), .clr_err(clr1),
        .done(done1), .mismatch(mis1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // JK bank models: Q+ = J&~Q | ~K&Q; bank 0 can have bits stuck at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= 8'h00;
            q1 <= 8'h00;
        end else begin
            q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~stuck;
            q1 <= (j1 & ~q1) | (~k1 & q1);
        end
    end

    assign oready = sel ? ready1 : ready0;
    assign odone  = sel ? done1  : done0;
    assign omis   = sel ? mis1   : mis0;
    assign obusy  = sel ? busy1  : busy0;
    assign oj     = sel ? j1     : j0;
    assign ok     = sel ? k1     : k0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        tdata = d;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    // Waits (bounded) for the first DRIVE cycle, then checks n targets
    // driven back-to-back using sj/sk as the expected excitations.
    task automatic stream_check(input int n, input int exp_wait);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (((oj | ok) == 8'h00) && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (exp_wait >= 0) chk("drive_latency", cnt, exp_wait);
        else chk("drive_timeout", 32'(cnt < 10), 1);
        for (int i = 0; i < n; i++) begin
            chk("j_drive", oj, sj[i]);
            chk("k_drive", ok, sk[i]);
            chk("done_at_drive", odone, 32'(i > 0));
            @(negedge clk);
            chk("jk_in_check", {oj, ok}, 0);
            chk("done_in_check", odone, 0);
            @(negedge clk);
        end
        chk("done_last", odone, 1);
        chk("mismatch_clear", omis, 0);
        @(negedge clk);
        chk("done_one_cycle", odone, 0);
        chk("busy_idle", obusy, 0);
    endtask

    initial begin
        vec_t vt [5];
        logic [7:0] words [4];
        vt[0] = '{tgt: 8'hA5, ej: 8'hA5, ek: 8'h00, s: 1'b0};
        vt[1] = '{tgt: 8'h3C, ej: 8'h18, ek: 8'h81, s: 1'b0};
        vt[2] = '{tgt: 8'h00, ej: 8'h00, ek: 8'h3C, s: 1'b0};
        vt[3] = '{tgt: 8'hA5, ej: 8'hA5, ek: 8'hA5, s: 1'b1};
        vt[4] = '{tgt: 8'h3C, ej: 8'h99, ek: 8'h99, s: 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_jk", {oj, ok}, 0);
            chk("rst_done", odone, 0);
            chk("rst_mismatch", omis, 0);
            chk("rst_busy", obusy, 0);
            chk("rst_ready", oready, 1);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // single targets from idle, both excitation modes
        for (int i = 0; i < 5; i++) begin
            sel   = vt[i].s;
            sj[0] = vt[i].ej;
            sk[0] = vt[i].ek;
            push(vt[i].tgt);
            stream_check(1, 1);
        end
        sel = 1'b0;

        // identical target (bank already 0x00): no excitation, done still pulses
        push(8'h00);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("same_jk_zero", {oj, ok}, 0);
            chk("same_done", odone, 32'(c == 4));
        end
        @(negedge clk);
        chk("same_busy", obusy, 0);

        // stuck bit0 -> mismatch and ERROR
        stuck = 8'h01;
        push(8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("stuck_j", oj, 8'h01);
        @(negedge clk);
        @(negedge clk);
        chk("stuck_mismatch", omis, 1);
        chk("stuck_no_done", odone, 0);
        words = '{8'h0F, 8'hF0, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_ready_before_push", oready, 1);
            valid0 = 1'b1;
            tdata  = words[i];
            @(posedge clk);
            #1;
            valid0 = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            chk("err_full_ready", oready, 0);
            chk("err_no_pop_jk", {oj, ok}, 0);
            chk("err_mismatch_held", omis, 1);
            chk("err_busy", obusy, 1);
            chk("err_no_done", odone, 0);
        end
        stuck = 8'h00;
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_mismatch", omis, 0);
        sj = '{8'h0F, 8'hF0, 8'h0F, 8'h00};
        sk = '{8'h00, 8'h0F, 8'h00, 8'hFF};
        stream_check(4, 1);

        // back-to-back pushes while the engine runs
        sj = '{8'h0F, 8'hF0, 8'h0F, 8'h00};
        sk = '{8'h00, 8'h0F, 8'h00, 8'h00};
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    valid0 = 1'b1;
                    tdata  = words[i];
                    @(posedge clk);
                end
                #1 valid0 = 1'b0;
            end
            stream_check(3, -1);
        join

        // reset during DRIVE with two words queued (model state 0xFF)
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid0 = 1'b1;
            tdata  = words[i];
            @(posedge clk);
        end
        @(negedge clk);
        valid0 = 1'b0;
        chk("pre_rst_j", oj, 8'h22);
        chk("pre_rst_k", ok, 8'h11);
        chk("pre_rst_busy", obusy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_jk", {oj, ok}, 0);
        chk("rst_mid_ready", oready, 1);
        chk("rst_mid_busy", obusy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_done", odone, 0);
            chk("post_rst_busy", obusy, 0);
            chk("post_rst_jk", {oj, ok}, 0);
            chk("post_rst_ready", oready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
